// File: rtl/vec_ds_responder.sv
// vec_ds_responder: downstream responder answering cache reads/evicts after fixed minimum latencies
// vec_ds_fifo ports: push_i/pl_i enqueue (when rdy_o), pop_i dequeues head (when vld_o), cnt_o occupancy.
// vec_ds_responder ports: txreq_* read requests, evict_* writes, rxdata_* read data, bresp_* write responses,
//   rd/wr_outstanding occupied queue entries; clk with synchronous active-high rst.
module vec_ds_fifo #(
  parameter int W     = 8,
  parameter int LAT   = 1,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic [W-1:0]             pl_i,
  input  logic                     pop_i,
  output logic                     rdy_o,
  output logic                     vld_o,
  output logic [W-1:0]             pl_o,
  output logic [$clog2(DEPTH):0]   cnt_o
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem_q [DEPTH];
  logic [7:0] cd_q [DEPTH];
  logic [AW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [AW:0] cnt_q, cnt_d;
  logic push, pop;
  always_comb begin
    rdy_o = cnt_q < (AW+1)'(DEPTH);
    vld_o = cnt_q != '0 && cd_q[rp_q] == 8'd0;
    push  = push_i && rdy_o;
    pop   = pop_i && vld_o;
    wp_d  = push ? wp_q + AW'(1) : wp_q;
    rp_d  = pop ? rp_q + AW'(1) : rp_q;
    cnt_d = cnt_q + (AW+1)'(push) - (AW+1)'(pop);
    pl_o  = mem_q[rp_q];
    cnt_o = cnt_q;
  end
  // every countdown ticks each cycle independent of stall; a fresh push overrides its slot
  always_ff @(posedge clk) begin
    if (rst) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++) cd_q[i] <= '0;
    end else begin
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      cnt_q <= cnt_d;
      for (int i = 0; i < DEPTH; i++)
        cd_q[i] <= (push && AW'(i) == wp_q) ? 8'(LAT - 1) : (cd_q[i] != 8'd0 ? cd_q[i] - 8'd1 : 8'd0);
    end
  end
  always_ff @(posedge clk) begin
    if (push) mem_q[wp_q] <= pl_i;
  end
endmodule

module vec_ds_responder #(
  parameter int ID_WIDTH       = 8,
  parameter int SIDEBAND_WIDTH = 4,
  parameter int RD_LAT         = 8,
  parameter int WR_LAT         = 4,
  parameter int RD_DEPTH       = 4,
  parameter int WR_DEPTH       = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          txreq_vld,
  output logic                          txreq_rdy,
  input  logic [63:0]                   txreq_addr,
  input  logic [ID_WIDTH-1:0]           txreq_txnid,
  input  logic [SIDEBAND_WIDTH-1:0]     txreq_sideband,
  input  logic                          evict_vld,
  output logic                          evict_rdy,
  input  logic [63:0]                   evict_addr,
  input  logic [1023:0]                 evict_data,
  input  logic [ID_WIDTH-1:0]           evict_txnid,
  input  logic [SIDEBAND_WIDTH-1:0]     evict_sideband,
  output logic                          rxdata_vld,
  input  logic                          rxdata_rdy,
  output logic [ID_WIDTH-1:0]           rxdata_txnid,
  output logic [1023:0]                 rxdata_data,
  output logic [SIDEBAND_WIDTH-1:0]     rxdata_sideband,
  output logic                          bresp_vld,
  input  logic                          bresp_rdy,
  output logic [ID_WIDTH-1:0]           bresp_txnid,
  output logic [SIDEBAND_WIDTH-1:0]     bresp_sideband,
  output logic [$clog2(RD_DEPTH):0]     rd_outstanding,
  output logic [$clog2(WR_DEPTH):0]     wr_outstanding
);
  localparam int RW = 64 + ID_WIDTH + SIDEBAND_WIDTH;
  localparam int WW = ID_WIDTH + SIDEBAND_WIDTH;
  logic [RW-1:0] rd_head;
  logic [WW-1:0] wr_head;
  // write payload is accepted and discarded; only id/sideband travel to bresp
  logic unused_evict;
  assign unused_evict = ^{evict_addr, evict_data};
  vec_ds_fifo #(.W(RW), .LAT(RD_LAT), .DEPTH(RD_DEPTH)) u_rd (
    .clk(clk), .rst(rst), .push_i(txreq_vld), .pl_i({txreq_addr, txreq_txnid, txreq_sideband}),
    .pop_i(rxdata_rdy), .rdy_o(txreq_rdy), .vld_o(rxdata_vld), .pl_o(rd_head), .cnt_o(rd_outstanding)
  );
  vec_ds_fifo #(.W(WW), .LAT(WR_LAT), .DEPTH(WR_DEPTH)) u_wr (
    .clk(clk), .rst(rst), .push_i(evict_vld), .pl_i({evict_txnid, evict_sideband}),
    .pop_i(bresp_rdy), .rdy_o(evict_rdy), .vld_o(bresp_vld), .pl_o(wr_head), .cnt_o(wr_outstanding)
  );
  // outputs read zero whenever no response is presented
  always_comb begin
    rxdata_txnid    = rxdata_vld ? rd_head[SIDEBAND_WIDTH +: ID_WIDTH] : '0;
    rxdata_sideband = rxdata_vld ? rd_head[SIDEBAND_WIDTH-1:0] : '0;
    rxdata_data     = '0;
    for (int k = 0; k < 16; k++)
      rxdata_data[64*k +: 64] = rxdata_vld ? rd_head[RW-1 -: 64] ^ 64'(k) : 64'd0;
    bresp_txnid     = bresp_vld ? wr_head[SIDEBAND_WIDTH +: ID_WIDTH] : '0;
    bresp_sideband  = bresp_vld ? wr_head[SIDEBAND_WIDTH-1:0] : '0;
  end
endmodule

// File: tb/tb_vec_ds_responder.sv
// tb_vec_ds_responder: table, directed and randomized model-based checks of vec_ds_responder
module tb_vec_ds_responder;
  localparam int IW = 8, SW = 4, RL = 8, WL = 4, RD = 4, WD = 4;
  logic clk = 0, rst = 1;
  always #5 clk = ~clk;
  logic txreq_vld, txreq_rdy, evict_vld, evict_rdy, rxdata_vld, rxdata_rdy, bresp_vld, bresp_rdy;
  logic [63:0] txreq_addr, evict_addr;
  logic [IW-1:0] txreq_txnid, evict_txnid, rxdata_txnid, bresp_txnid;
  logic [SW-1:0] txreq_sideband, evict_sideband, rxdata_sideband, bresp_sideband;
  logic [1023:0] evict_data, rxdata_data;
  logic [2:0] rd_outstanding, wr_outstanding;
  vec_ds_responder #(.ID_WIDTH(IW), .SIDEBAND_WIDTH(SW), .RD_LAT(RL), .WR_LAT(WL), .RD_DEPTH(RD), .WR_DEPTH(WD)) dut (
    .clk(clk), .rst(rst), .txreq_vld(txreq_vld), .txreq_rdy(txreq_rdy), .txreq_addr(txreq_addr),
    .txreq_txnid(txreq_txnid), .txreq_sideband(txreq_sideband), .evict_vld(evict_vld), .evict_rdy(evict_rdy),
    .evict_addr(evict_addr), .evict_data(evict_data), .evict_txnid(evict_txnid), .evict_sideband(evict_sideband),
    .rxdata_vld(rxdata_vld), .rxdata_rdy(rxdata_rdy), .rxdata_txnid(rxdata_txnid), .rxdata_data(rxdata_data),
    .rxdata_sideband(rxdata_sideband), .bresp_vld(bresp_vld), .bresp_rdy(bresp_rdy), .bresp_txnid(bresp_txnid),
    .bresp_sideband(bresp_sideband), .rd_outstanding(rd_outstanding), .wr_outstanding(wr_outstanding)
  );
  int n_cmp = 0, n_bad = 0, cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  typedef struct {logic tv; logic rr; logic e_rdy; int e_out; logic e_vld; int e_id;} vec_t;
  typedef struct {logic [63:0] a; logic [IW-1:0] id; logic [SW-1:0] sb; int t;} ent_t;
  vec_t tbl[14];
  ent_t rq[$], wq[$];
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic idle;
    txreq_vld = 0; txreq_addr = '0; txreq_txnid = '0; txreq_sideband = '0; rxdata_rdy = 0;
    evict_vld = 0; evict_addr = '0; evict_data = '0; evict_txnid = '0; evict_sideband = '0; bresp_rdy = 0;
  endtask
  task automatic do_reset;
    idle;
    rst = 1;
    tick;
    tick;
    rst = 0;
  endtask
  task automatic rd_req(input logic [63:0] a, input int id);
    txreq_vld = 1; txreq_addr = a; txreq_txnid = IW'(id); txreq_sideband = SW'(id);
  endtask
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
  initial begin
    tbl = '{
      '{1, 0, 1, 0, 0, 0}, '{1, 0, 1, 1, 0, 0}, '{1, 0, 1, 2, 0, 0}, '{1, 0, 1, 3, 0, 0},
      '{1, 0, 0, 4, 0, 0}, '{0, 0, 0, 4, 0, 0}, '{0, 0, 0, 4, 0, 0}, '{0, 0, 0, 4, 0, 0},
      '{0, 1, 0, 4, 1, 0}, '{0, 0, 1, 3, 1, 1}, '{0, 1, 1, 3, 1, 1}, '{0, 1, 1, 2, 1, 2},
      '{0, 1, 1, 1, 1, 3}, '{0, 0, 1, 0, 0, 0}};
    idle;
    @(negedge clk);
    do_reset;
    chk("rst_rxdata_vld", 64'(rxdata_vld), 0);
    chk("rst_bresp_vld", 64'(bresp_vld), 0);
    chk("rst_txreq_rdy", 64'(txreq_rdy), 1);
    chk("rst_evict_rdy", 64'(evict_rdy), 1);
    chk("rst_outstanding", 64'({rd_outstanding, wr_outstanding}), 0);
    chk("rst_outputs_zero", 64'(|{rxdata_data, rxdata_txnid, rxdata_sideband, bresp_txnid, bresp_sideband}), 0);
    // single read latency and data lanes
    rxdata_rdy = 1;
    rd_req(64'h1000, 3);
    tick;
    txreq_vld = 0;
    for (int i = 1; i < RL; i++) begin
      chk("single_early_vld", 64'(rxdata_vld), 0);
      tick;
    end
    chk("single_vld", 64'(rxdata_vld), 1);
    chk("single_txnid", 64'(rxdata_txnid), 3);
    chk("single_lane0", rxdata_data[63:0], 64'h1000);
    chk("single_lane15", rxdata_data[1023:960], 64'h100F);
    tick;
    chk("single_popped", 64'(rxdata_vld), 0);
    // table-driven fill and drain
    do_reset;
    for (int r = 0; r < 14; r++) begin
      chk("tbl_rdy", 64'(txreq_rdy), 64'(tbl[r].e_rdy));
      chk("tbl_outstanding", 64'(rd_outstanding), 64'(tbl[r].e_out));
      chk("tbl_vld", 64'(rxdata_vld), 64'(tbl[r].e_vld));
      if (tbl[r].e_vld) chk("tbl_txnid", 64'(rxdata_txnid), 64'(tbl[r].e_id));
      txreq_vld = tbl[r].tv; txreq_txnid = IW'(r); txreq_addr = 64'(r) << 8; rxdata_rdy = tbl[r].rr;
      tick;
    end
    // backpressure: outputs hold, then drain back-to-back
    do_reset;
    for (int i = 0; i < 4; i++) begin
      rd_req(64'h40 * i, 10 + i);
      tick;
    end
    txreq_vld = 0;
    for (int w = 0; w < 20 && !rxdata_vld; w++) tick;
    chk("bp_wait_vld", 64'(rxdata_vld), 1);
    for (int i = 0; i < 20; i++) begin
      chk("bp_hold_vld", 64'(rxdata_vld), 1);
      chk("bp_hold_txnid", 64'(rxdata_txnid), 10);
      chk("bp_hold_lane3", rxdata_data[255:192], 64'h3);
      tick;
    end
    rxdata_rdy = 1;
    for (int j = 0; j < 4; j++) begin
      chk("bp_drain_vld", 64'(rxdata_vld), 1);
      chk("bp_drain_txnid", 64'(rxdata_txnid), 64'(10 + j));
      chk("bp_drain_lane1", rxdata_data[127:64], (64'h40 * j) ^ 64'h1);
      tick;
    end
    chk("bp_empty", 64'(rxdata_vld), 0);
    // concurrent read and write
    do_reset;
    rxdata_rdy = 1; bresp_rdy = 1;
    rd_req(64'h2000, 7);
    evict_vld = 1; evict_txnid = 8'd9; evict_sideband = 4'h5;
    tick;
    idle;
    rxdata_rdy = 1; bresp_rdy = 1;
    for (int r = 1; r <= RL; r++) begin
      chk("conc_bresp_vld", 64'(bresp_vld), 64'(r == WL));
      chk("conc_rxdata_vld", 64'(rxdata_vld), 64'(r == RL));
      if (r == WL) chk("conc_bresp_id", 64'({bresp_txnid, bresp_sideband}), 64'h95);
      if (r == RL) chk("conc_rxdata_id", 64'(rxdata_txnid), 7);
      tick;
    end
    // reset mid-flight, with a request offered during reset
    do_reset;
    for (int i = 0; i < 3; i++) begin
      rd_req(64'h3000 + 64'(i), i);
      tick;
    end
    chk("rmf_outstanding_pre", 64'(rd_outstanding), 3);
    rst = 1;
    tick;
    rst = 0; txreq_vld = 0; rxdata_rdy = 1;
    chk("rmf_outstanding", 64'(rd_outstanding), 0);
    chk("rmf_rdy", 64'(txreq_rdy), 1);
    for (int i = 0; i < 12; i++) begin
      chk("rmf_no_vld", 64'(rxdata_vld), 0);
      tick;
    end
    // write wrap: 10 writes through a depth-4 queue
    do_reset;
    bresp_rdy = 1;
    begin
      int sent, nexp;
      sent = 0; nexp = 0;
      for (int c = 0; c < 100; c++) begin
        if (bresp_vld) begin
          chk("wrap_bresp_txnid", 64'(bresp_txnid), 64'(nexp));
          nexp++;
        end
        evict_vld = sent < 10; evict_txnid = IW'(sent);
        if (evict_vld && evict_rdy) sent++;
        tick;
      end
      chk("wrap_count", 64'(nexp), 10);
    end
    // randomized traffic against a queue model
    do_reset;
    for (int n = 0; n < 3000; n++) begin
      logic e_rv, e_wv, racc, wacc;
      logic [63:0] r64;
      e_rv = rq.size() > 0 && cyc >= rq[0].t + RL - 1;
      e_wv = wq.size() > 0 && cyc >= wq[0].t + WL - 1;
      chk("rnd_txreq_rdy", 64'(txreq_rdy), 64'(rq.size() < RD));
      chk("rnd_evict_rdy", 64'(evict_rdy), 64'(wq.size() < WD));
      chk("rnd_rd_outstanding", 64'(rd_outstanding), 64'(rq.size()));
      chk("rnd_wr_outstanding", 64'(wr_outstanding), 64'(wq.size()));
      chk("rnd_rxdata_vld", 64'(rxdata_vld), 64'(e_rv));
      chk("rnd_bresp_vld", 64'(bresp_vld), 64'(e_wv));
      if (e_rv) begin
        chk("rnd_rxdata_id", 64'({rxdata_txnid, rxdata_sideband}), 64'({rq[0].id, rq[0].sb}));
        for (int k = 0; k < 16; k++) chk("rnd_rxdata_lane", rxdata_data[64*k +: 64], rq[0].a ^ 64'(k));
      end
      if (e_wv) chk("rnd_bresp_id", 64'({bresp_txnid, bresp_sideband}), 64'({wq[0].id, wq[0].sb}));
      r64 = {$urandom, $urandom};
      txreq_vld = $urandom_range(0, 99) < 50; txreq_addr = r64;
      txreq_txnid = IW'($urandom); txreq_sideband = SW'($urandom);
      rxdata_rdy = $urandom_range(0, 99) < 40;
      evict_vld = $urandom_range(0, 99) < 50; evict_addr = ~r64; evict_data = {16{r64}};
      evict_txnid = IW'($urandom); evict_sideband = SW'($urandom);
      bresp_rdy = $urandom_range(0, 99) < 40;
      racc = txreq_vld && rq.size() < RD;
      wacc = evict_vld && wq.size() < WD;
      if (e_rv && rxdata_rdy) void'(rq.pop_front());
      if (e_wv && bresp_rdy) void'(wq.pop_front());
      if (racc) rq.push_back('{txreq_addr, txreq_txnid, txreq_sideband, cyc + 1});
      if (wacc) wq.push_back('{64'd0, evict_txnid, evict_sideband, cyc + 1});
      tick;
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
